// File: rtl/mem_memory_pipe_if.sv
// Request/response bundle for the dual-port pipelined memory: an instruction fetch port and a data port.
// The master modport belongs to the core side and the slave modport belongs to the memory.
interface mem_memory_pipe_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;

    logic        data_req;
    logic        data_we;
    logic [1:0]  data_size;
    logic        data_unsigned;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        data_fault;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_valid, fetch_instr, fetch_fault,
        output data_req, data_we, data_size, data_unsigned, data_addr, data_wdata,
        input  data_valid, data_rdata, data_fault
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_valid, fetch_instr, fetch_fault,
        input  data_req, data_we, data_size, data_unsigned, data_addr, data_wdata,
        output data_valid, data_rdata, data_fault
    );
endinterface

// File: rtl/mem_memory_pipe.sv
// Word-organised RAM with a read-only fetch port and a load/store port, both pipelined to READ_LATENCY.
// Optional: MEM_STORE_FWD_EN forwards recent stores.
module mem_memory_pipe #(
    parameter int DEPTH_WORDS   = 8192,
    parameter int READ_LATENCY  = 1,
    parameter     INIT_FILENAME = "test_rv32i.bin"
) (
    input logic               i_clk,
    input logic               i_reset_n,
    mem_memory_pipe_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("mem_memory_pipe: READ_LATENCY must be within 1..4");
        end
        if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
            $error("mem_memory_pipe: DEPTH_WORDS must be a power of two");
        end
    endgenerate

    typedef struct packed {
        logic       valid;
        logic       fault;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] lane;
    } d_ctl_t;

    typedef struct packed {
        d_ctl_t      ctl;
        logic [31:0] word;
    } d_stage_t;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] word;
    } i_stage_t;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [31:0] a);
        return (a >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    logic [AW-1:0] d_idx;
    logic [AW-1:0] i_idx;
    logic          d_fault_req;
    logic          i_fault_req;
    logic          st_en;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign d_idx = bus.data_addr[AW+1:2];
    assign i_idx = bus.fetch_addr[AW+1:2];
    assign i_fault_req = !in_range(bus.fetch_addr) || (bus.fetch_addr[1:0] != 2'b00);

    always_comb begin
        d_fault_req = !in_range(bus.data_addr);
        st_be       = 4'b0000;
        st_data     = bus.data_wdata;
        unique case (bus.data_size)
            2'b00: begin
                st_be   = 4'b0001 << bus.data_addr[1:0];
                st_data = {4{bus.data_wdata[7:0]}};
            end
            2'b01: begin
                if (bus.data_addr[0]) d_fault_req = 1'b1;
                st_be   = bus.data_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.data_wdata[15:0]}};
            end
            2'b10: begin
                if (bus.data_addr[1:0] != 2'b00) d_fault_req = 1'b1;
                st_be = 4'b1111;
            end
            default: d_fault_req = 1'b1;
        endcase
        // a store coinciding with reset is dropped, as is any faulting store
        st_en = i_reset_n && bus.data_req && bus.data_we && !d_fault_req;
        if (!st_en) st_be = 4'b0000;
    end

    logic [31:0] d_raw;
    logic [31:0] i_raw;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem[d_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
        d_raw <= mem[d_idx];
        i_raw <= mem[i_idx];
    end

    d_ctl_t      d_ctl1;
    logic        i_v1;
    logic        i_f1;
    logic [31:0] d_word1;
    logic [31:0] i_word1;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            d_ctl1 <= '0;
            i_v1   <= 1'b0;
            i_f1   <= 1'b0;
        end else begin
            d_ctl1.valid <= bus.data_req;
            d_ctl1.fault <= d_fault_req;
            d_ctl1.we    <= bus.data_we;
            d_ctl1.size  <= bus.data_size;
            d_ctl1.uns   <= bus.data_unsigned;
            d_ctl1.lane  <= bus.data_addr[1:0];
            i_v1         <= bus.fetch_req;
            i_f1         <= i_fault_req;
        end
    end

`ifdef MEM_STORE_FWD_EN
    logic          prev_st_v;
    logic [AW-1:0] prev_idx;
    logic [31:0]   prev_data;
    logic [3:0]    prev_be;
    logic          d_fwd;
    logic [31:0]   d_fwd_data;
    logic [3:0]    d_fwd_be;
    logic          i_fwd;
    logic [31:0]   i_fwd_data;
    logic [3:0]    i_fwd_be;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            prev_st_v <= 1'b0;
            d_fwd     <= 1'b0;
            i_fwd     <= 1'b0;
        end else begin
            prev_st_v <= st_en;
            d_fwd     <= bus.data_req && !bus.data_we && prev_st_v && (d_idx == prev_idx);
            i_fwd     <= bus.fetch_req && st_en && (i_idx == d_idx);
        end
        prev_idx   <= d_idx;
        prev_data  <= st_data;
        prev_be    <= st_be;
        d_fwd_data <= prev_data;
        d_fwd_be   <= prev_be;
        i_fwd_data <= st_data;
        i_fwd_be   <= st_be;
    end

    assign d_word1 = d_fwd ? merge(d_raw, d_fwd_data, d_fwd_be) : d_raw;
    assign i_word1 = i_fwd ? merge(i_raw, i_fwd_data, i_fwd_be) : i_raw;
`else
    assign d_word1 = d_raw;
    assign i_word1 = i_raw;
`endif

    d_stage_t d_s1;
    i_stage_t i_s1;
    d_stage_t d_dly [3];
    i_stage_t i_dly [3];
    d_stage_t d_fin;
    i_stage_t i_fin;

    assign d_s1 = '{ctl: d_ctl1, word: d_word1};
    assign i_s1 = '{valid: i_v1, fault: i_f1, word: i_word1};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < 3; k++) begin
                d_dly[k] <= '0;
                i_dly[k] <= '0;
            end
        end else begin
            d_dly[0] <= d_s1;
            i_dly[0] <= i_s1;
            for (int k = 1; k < 3; k++) begin
                d_dly[k] <= d_dly[k-1];
                i_dly[k] <= i_dly[k-1];
            end
        end
    end

    always_comb begin
        d_fin = d_s1;
        i_fin = i_s1;
        for (int k = 0; k < 3; k++) begin
            if (k == READ_LATENCY - 2) begin
                d_fin = d_dly[k];
                i_fin = i_dly[k];
            end
        end
    end

    logic [31:0] d_ext;
    logic [7:0]  ext_b;
    logic [15:0] ext_h;

    always_comb begin
        ext_b = d_fin.word[{d_fin.ctl.lane, 3'b000} +: 8];
        ext_h = d_fin.ctl.lane[1] ? d_fin.word[31:16] : d_fin.word[15:0];
        unique case (d_fin.ctl.size)
            2'b00:   d_ext = d_fin.ctl.uns ? {24'd0, ext_b} : {{24{ext_b[7]}}, ext_b};
            2'b01:   d_ext = d_fin.ctl.uns ? {16'd0, ext_h} : {{16{ext_h[15]}}, ext_h};
            default: d_ext = d_fin.word;
        endcase
        if (!d_fin.ctl.valid || d_fin.ctl.fault || d_fin.ctl.we) d_ext = 32'd0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            bus.data_valid  <= 1'b0;
            bus.data_rdata  <= 32'd0;
            bus.data_fault  <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_instr <= 32'd0;
            bus.fetch_fault <= 1'b0;
        end else begin
            bus.data_valid  <= d_fin.ctl.valid;
            bus.data_rdata  <= d_ext;
            bus.data_fault  <= d_fin.ctl.valid && d_fin.ctl.fault;
            bus.fetch_valid <= i_fin.valid;
            bus.fetch_instr <= (i_fin.valid && !i_fin.fault) ? i_fin.word : 32'd0;
            bus.fetch_fault <= i_fin.valid && i_fin.fault;
        end
    end
endmodule
